// File: rtl/sampling_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sampling_pkg
//  Description : Shared constants for the serial-to-parallel sampler: default
//                feedback tap masks and the mode encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package sampling_pkg;

    // Default feedback taps; bit i set => sr[i] takes part in the feedback XOR
    localparam logic [7:0]  TAPS_8  = 8'h41;
    localparam logic [15:0] TAPS_16 = 16'h8016;
    localparam logic [31:0] TAPS_32 = 32'h8020_0003;

    // Mode encoding
    localparam logic MODE_WHITEN = 1'b0;
    localparam logic MODE_RAW    = 1'b1;

endpackage : sampling_pkg
`default_nettype wire

// File: rtl/sampling_stream_if.sv
`default_nettype none
// ============================================================================
//  Module      : sampling_stream_if
//  Description : Bit-in / word-out stream bundle. The master side supplies
//                serial bits and consumes words; the slave side is the sampler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sampling_stream_if #(
    parameter int OUT_W = 8
);
    logic             in_valid;
    logic             in_bit;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    modport master (
        output in_valid,
        output in_bit,
        output out_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_bit,
        input  out_ready,
        output out_valid,
        output out_data
    );
endinterface : sampling_stream_if
`default_nettype wire

// File: rtl/sampling_stream_lfsr_shift.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_shift
//  Description : OUT_W-bit shift register with synchronous clear, seed load,
//                shift enable and optional LFSR feedback (bypassed in raw mode).
//                New bits enter at bit 0 so the first bit reaches the MSB after
//                OUT_W shifts.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_shift
    import sampling_pkg::*;
#(
    parameter int               OUT_W    = 8,
    parameter logic [OUT_W-1:0] TAP_MASK = OUT_W'(TAPS_8)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clr,
    input  wire logic             i_load,
    input  wire logic [OUT_W-1:0] i_seed,
    input  wire logic             i_shift,
    input  wire logic             i_mode,
    input  wire logic             i_bit,
    output logic      [OUT_W-1:0] o_sr,
    output logic      [OUT_W-1:0] o_sr_next
);

    logic [OUT_W-1:0] r_sr;
    logic             w_fb;

    // Feedback: incoming bit, optionally whitened by the parity of the tapped bits
    always_comb begin
        w_fb = i_bit ^ ((i_mode == MODE_RAW) ? 1'b0 : ^(r_sr & TAP_MASK));
    end

    assign o_sr_next = {r_sr[OUT_W-2:0], w_fb};
    assign o_sr      = r_sr;

    // Register update: clear beats load beats shift
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_sr <= '0;
        end else if (i_load) begin
            r_sr <= i_seed;
        end else if (i_shift) begin
            r_sr <= o_sr_next;
        end
    end

endmodule : lfsr_shift
`default_nettype wire

// File: rtl/sampling_stream.sv
`default_nettype none
// ============================================================================
//  Module      : sampling_stream
//  Description : Serial-to-parallel sampler. Folds accepted bits into an
//                OUT_W-bit (optionally whitened) shift register and emits the
//                register value every SAMPLE_CNT accepted bits into a one-entry
//                valid/ready buffer with a sticky overflow flag on drop.
//  Revision    : 1.0 - initial release
// ============================================================================
module sampling_stream
    import sampling_pkg::*;
#(
    parameter int               OUT_W         = 8,
    parameter int               SAMPLE_CNT    = 64,
    parameter logic [OUT_W-1:0] TAP_MASK      = OUT_W'(TAPS_8),
    parameter bit               CLEAR_ON_EMIT = 1'b1
) (
    input  wire logic                              clk,
    input  wire logic                              rst,
    input  wire logic                              enable,
    input  wire logic                              load,
    input  wire logic [OUT_W-1:0]                  seed,
    input  wire logic                              mode,
    sampling_stream_if.slave                       bus,
    output logic                                   overflow,
    output logic [$clog2(SAMPLE_CNT+1)-1:0]        bit_count
);

    localparam int                c_CW   = $clog2(SAMPLE_CNT + 1);
    localparam logic [c_CW-1:0]   c_LAST = c_CW'(SAMPLE_CNT - 1);

    logic [c_CW-1:0]  r_count;
    logic             r_valid;
    logic [OUT_W-1:0] r_data;
    logic             r_overflow;

    logic             w_accept;
    logic             w_emit;
    logic             w_clr;
    logic [OUT_W-1:0] w_sr_next;
    logic [OUT_W-1:0] w_sr_unused;

    // Accept/emit decode; a disabled block or a clearing emit wipes the register
    always_comb begin
        w_accept = enable & ~load & bus.in_valid;
        w_emit   = w_accept & (r_count == c_LAST);
        w_clr    = ~enable | (w_emit & CLEAR_ON_EMIT);
    end

    lfsr_shift #(
        .OUT_W    (OUT_W),
        .TAP_MASK (TAP_MASK)
    ) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_clr),
        .i_load    (load),
        .i_seed    (seed),
        .i_shift   (w_accept),
        .i_mode    (mode),
        .i_bit     (bus.in_bit),
        .o_sr      (w_sr_unused),
        .o_sr_next (w_sr_next)
    );

    // Bit counter: restarts on disable, load and emit; never passes SAMPLE_CNT-1
    always_ff @(posedge clk) begin
        if (rst || !enable || load) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= w_emit ? '0 : r_count + 1'b1;
        end
    end

    // One-entry output buffer: an emit refills even when the held word is being
    // consumed this cycle; an emit onto an unconsumed word is dropped and flagged
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_emit) begin
                if (r_valid && !bus.out_ready) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_data  <= w_sr_next;
                    r_valid <= 1'b1;
                end
            end else if (r_valid && bus.out_ready) begin
                r_valid <= 1'b0;
            end
            // load never coincides with an emit, so this cannot mask a new drop
            if (enable && load) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.out_data  = r_data;
    assign overflow      = r_overflow;
    assign bit_count     = r_count;

endmodule : sampling_stream
`default_nettype wire

// File: tb/tb_sampling_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sampling_stream
//  Description : Self-checking bench for sampling_stream. Three instances
//                (SAMPLE_CNT 8/clear, 1/clear, 5/keep) share one stimulus and
//                are compared every cycle against a behavioural model, plus a
//                directed vector table and hand-written corner sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sampling_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       t_rst = 1'b1, t_en = 1'b0, t_ld = 1'b0, t_md = 1'b1;
    logic       t_iv = 1'b0, t_ib = 1'b0, t_rdy = 1'b0;
    logic [7:0] t_sd = 8'h00;

    int n_chk = 0;
    int n_bad = 0;

    sampling_stream_if #(.OUT_W(8)) bus_a ();
    sampling_stream_if #(.OUT_W(8)) bus_b ();
    sampling_stream_if #(.OUT_W(8)) bus_c ();

    assign bus_a.in_valid = t_iv;  assign bus_a.in_bit = t_ib;  assign bus_a.out_ready = t_rdy;
    assign bus_b.in_valid = t_iv;  assign bus_b.in_bit = t_ib;  assign bus_b.out_ready = t_rdy;
    assign bus_c.in_valid = t_iv;  assign bus_c.in_bit = t_ib;  assign bus_c.out_ready = t_rdy;

    logic       ovf_a, ovf_b, ovf_c;
    logic [3:0] cnt_a;
    logic [0:0] cnt_b;
    logic [2:0] cnt_c;

    sampling_stream #(.OUT_W(8), .SAMPLE_CNT(8), .TAP_MASK(8'h41), .CLEAR_ON_EMIT(1'b1)) dut_a (
        .clk(clk), .rst(t_rst), .enable(t_en), .load(t_ld), .seed(t_sd), .mode(t_md),
        .bus(bus_a), .overflow(ovf_a), .bit_count(cnt_a));
    sampling_stream #(.OUT_W(8), .SAMPLE_CNT(1), .TAP_MASK(8'h41), .CLEAR_ON_EMIT(1'b1)) dut_b (
        .clk(clk), .rst(t_rst), .enable(t_en), .load(t_ld), .seed(t_sd), .mode(t_md),
        .bus(bus_b), .overflow(ovf_b), .bit_count(cnt_b));
    sampling_stream #(.OUT_W(8), .SAMPLE_CNT(5), .TAP_MASK(8'h41), .CLEAR_ON_EMIT(1'b0)) dut_c (
        .clk(clk), .rst(t_rst), .enable(t_en), .load(t_ld), .seed(t_sd), .mode(t_md),
        .bus(bus_c), .overflow(ovf_c), .bit_count(cnt_c));

    // ---------------- behavioural reference model ----------------
    int         P_N[3] = '{8, 1, 5};
    bit         P_C[3] = '{1'b1, 1'b1, 1'b0};
    logic [7:0] m_sr[3];
    logic [7:0] m_data[3];
    bit         m_valid[3];
    bit         m_ovf[3];
    int         m_cnt[3];

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            bit         emitted;
            bit         fb;
            logic [7:0] nx;
            emitted = 1'b0;
            if (t_rst) begin
                m_sr[k] = 8'h00; m_cnt[k] = 0; m_valid[k] = 1'b0; m_data[k] = 8'h00; m_ovf[k] = 1'b0;
            end else begin
                if (!t_en) begin
                    m_sr[k] = 8'h00; m_cnt[k] = 0;
                end else if (t_ld) begin
                    m_sr[k] = t_sd; m_cnt[k] = 0; m_ovf[k] = 1'b0;
                end else if (t_iv) begin
                    fb = t_ib;
                    if (!t_md && ($countones(m_sr[k] & 8'h41) % 2 == 1)) fb = ~fb;
                    nx = m_sr[k] * 2 + {7'd0, fb};
                    if (m_cnt[k] == P_N[k] - 1) begin
                        emitted  = 1'b1;
                        m_cnt[k] = 0;
                        m_sr[k]  = P_C[k] ? 8'h00 : nx;
                        if (m_valid[k] && !t_rdy) m_ovf[k] = 1'b1;
                        else begin m_data[k] = nx; m_valid[k] = 1'b1; end
                    end else begin
                        m_sr[k]  = nx;
                        m_cnt[k] = m_cnt[k] + 1;
                    end
                end
                if (!emitted && m_valid[k] && t_rdy) m_valid[k] = 1'b0;
            end
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("A.valid", int'(bus_a.out_valid), int'(m_valid[0]));
        chk("A.data",  int'(bus_a.out_data),  int'(m_data[0]));
        chk("A.ovf",   int'(ovf_a),           int'(m_ovf[0]));
        chk("A.cnt",   int'(cnt_a),           m_cnt[0]);
        chk("B.valid", int'(bus_b.out_valid), int'(m_valid[1]));
        chk("B.data",  int'(bus_b.out_data),  int'(m_data[1]));
        chk("B.ovf",   int'(ovf_b),           int'(m_ovf[1]));
        chk("B.cnt",   int'(cnt_b),           m_cnt[1]);
        chk("C.valid", int'(bus_c.out_valid), int'(m_valid[2]));
        chk("C.data",  int'(bus_c.out_data),  int'(m_data[2]));
        chk("C.ovf",   int'(ovf_c),           int'(m_ovf[2]));
        chk("C.cnt",   int'(cnt_c),           m_cnt[2]);
    endtask

    // Apply one cycle of inputs, advance the model at the edge, compare just after
    task automatic step(input logic r, input logic e, input logic l, input logic [7:0] s,
                        input logic m, input logic v, input logic b, input logic rd);
        t_rst = r; t_en = e; t_ld = l; t_sd = s; t_md = m; t_iv = v; t_ib = b; t_rdy = rd;
        @(posedge clk);
        model_step();
        #1;
        chk_model();
    endtask

    // Feed a byte MSB first as raw/whitened accepted bits
    task automatic feed(input logic [7:0] w, input int nbits, input logic m, input logic rd);
        for (int i = 7; i > 7 - nbits; i--) step(1'b0, 1'b1, 1'b0, 8'h00, m, 1'b1, w[i], rd);
    endtask

    // ---------------- directed vector table (instance A) ----------------
    typedef struct {
        logic       rst, en, ld;
        logic [7:0] sd;
        logic       md, iv, ib, rdy;
        logic       ev;
        logic [7:0] ed;
        logic       eo;
        int         ec;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic [7:0] pat;
        pat = 8'hB2;
        tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0};
        for (int i = 0; i < 8; i++)
            tbl[2+i] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, pat[7-i], 1'b0,
                         (i == 7), (i == 7) ? 8'hB2 : 8'h00, 1'b0, (i == 7) ? 0 : i + 1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hB2, 1'b0, 0};

        for (int i = 0; i < 3; i++) begin
            m_sr[i] = 8'h00; m_data[i] = 8'h00; m_valid[i] = 1'b0; m_ovf[i] = 1'b0; m_cnt[i] = 0;
        end

        // Raw 8-bit word 0xB2, one-cycle emit latency, counter back to 0
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].ld, tbl[i].sd, tbl[i].md, tbl[i].iv, tbl[i].ib, tbl[i].rdy);
            chk("tbl.valid", int'(bus_a.out_valid), int'(tbl[i].ev));
            chk("tbl.data",  int'(bus_a.out_data),  int'(tbl[i].ed));
            chk("tbl.ovf",   int'(ovf_a),           int'(tbl[i].eo));
            chk("tbl.cnt",   int'(cnt_a),           tbl[i].ec);
        end

        // SAMPLE_CNT=1 whitened: seed 0x01, bit 0 -> 0x03; cleared sr gives 0x01 next
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("s2.B.data",  int'(bus_b.out_data),  8'h03);
        chk("s2.B.valid", int'(bus_b.out_valid), 1);
        chk("s2.B.cnt",   int'(cnt_b),           0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("s2.B.clr",   int'(bus_b.out_data),  8'h01);
        chk("s2.B.ovf",   int'(ovf_b),           0);

        // Backpressure: 16 bits with out_ready=0 keep the first word and flag overflow
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        feed(8'h5C, 8, 1'b1, 1'b0);
        chk("s3.first", int'(bus_a.out_data), 8'h5C);
        chk("s3.ovf0",  int'(ovf_a),          0);
        feed(8'hE1, 8, 1'b1, 1'b0);
        chk("s3.kept",  int'(bus_a.out_data), 8'h5C);
        chk("s3.ovf1",  int'(ovf_a),          1);
        step(1'b0, 1'b1, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("s3.ldovf", int'(ovf_a),           0);
        chk("s3.ldval", int'(bus_a.out_valid), 1);

        // Consume and refill in the same cycle: new word, valid stays, no overflow
        feed(8'h3A, 7, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("s4.valid", int'(bus_a.out_valid), 1);
        chk("s4.data",  int'(bus_a.out_data),  8'h3A);
        chk("s4.ovf",   int'(ovf_a),           0);

        // Disable mid-word restarts the word; buffer untouched
        feed(8'hA8, 5, 1'b1, 1'b0);
        chk("s5.cnt5",  int'(cnt_a), 5);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("s5.cnt0",  int'(cnt_a),           0);
        chk("s5.keep",  int'(bus_a.out_data),  8'h3A);
        chk("s5.kval",  int'(bus_a.out_valid), 1);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        feed(8'h96, 8, 1'b0, 1'b1);
        feed(8'h96, 3, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("s5.rval",  int'(bus_a.out_valid), 0);
        chk("s5.rdata", int'(bus_a.out_data),  0);
        chk("s5.rovf",  int'(ovf_a),           0);
        chk("s5.rcnt",  int'(cnt_a),           0);

        // Load together with in_valid: seed loaded, bit ignored
        step(1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("s6.cnt",   int'(cnt_a),           0);
        chk("s6.noemit", int'(bus_b.out_valid), 0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("s6.seed",  int'(bus_b.out_data),  8'h4B);
        chk("s6.cnt1",  int'(cnt_a),           1);

        // Randomised traffic against the model
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) != 0),
                 ($urandom_range(0, 24) == 0), 8'($urandom), 1'($urandom),
                 ($urandom_range(0, 9) < 7), 1'($urandom), ($urandom_range(0, 2) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule : tb_sampling_stream
`default_nettype wire
